// File: rtl/blur_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blur_pkg
// Brief    : Shared state encoding, pixel/channel layout and blur kernel.
// Revision : 1.0 - initial release
// ============================================================================
package blur_pkg;

  localparam int PIX_W = 12;
  localparam int CH_W  = 4;
  localparam int R_LSB = 8;
  localparam int G_LSB = 4;
  localparam int B_LSB = 0;

  // 8 bits hold the worst-case weighted sum (240) plus the rounding term.
  localparam int                SUM_W = 8;
  localparam logic [SUM_W-1:0]  RND   = 8'd8;
  localparam int                SHIFT = 4;

  // Row-major 3x3 kernel [1 2 1; 2 4 2; 1 2 1].
  localparam logic [8:0][2:0] KW = {3'd1, 3'd2, 3'd1,
                                    3'd2, 3'd4, 3'd2,
                                    3'd1, 3'd2, 3'd1};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [CH_W-1:0] blur_ch(input logic [8:0][CH_W-1:0] taps);
    logic [SUM_W-1:0] sum;
    sum = RND;
    for (int i = 0; i < 9; i++) begin
      sum = sum + SUM_W'(taps[i]) * SUM_W'(KW[i]);
    end
    return sum[SHIFT +: CH_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/blur_if.sv
`default_nettype none
// ============================================================================
// Module   : blur_if
// Brief    : Start/done handshake plus source and destination frame ports.
// Revision : 1.0 - initial release
// ============================================================================
interface blur_if #(
  parameter int ADDR_W = 17
);
  import blur_pkg::*;

  logic                blur_start;
  logic [ADDR_W-1:0]   src_addr;
  logic [PIX_W-1:0]    src_data;
  logic [ADDR_W-1:0]   dst_addr;
  logic [PIX_W-1:0]    dst_data;
  logic                dst_we;
  logic                busy;
  logic                blur_done;

  modport master (
    output blur_start, src_data,
    input  src_addr, dst_addr, dst_data, dst_we, busy, blur_done
  );

  modport slave (
    input  blur_start, src_data,
    output src_addr, dst_addr, dst_data, dst_we, busy, blur_done
  );

endinterface
`default_nettype wire

// File: rtl/blur_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : blur_line_buffer
// Brief    : DEPTH-deep pixel delay line; dout_o is the pixel pushed DEPTH pushes ago.
// Revision : 1.0 - initial release
// ============================================================================
module blur_line_buffer import blur_pkg::*; #(
  parameter int DEPTH = 320
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout_o
);

  localparam int               PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (push_i) begin
      ptr_q <= (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
    end
  end

  // The slot about to be overwritten holds the oldest entry.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

  assign dout_o = mem_q[ptr_q];

endmodule
`default_nettype wire

// File: rtl/blur_engine.sv
`default_nettype none
// ============================================================================
// Module   : blur_engine
// Brief    : Raster-streaming 3x3 Gaussian blur, one read and one write per cycle.
//            BLUR_BORDER_COPY_EN: border pixels copy the source instead of black.
// Revision : 1.0 - initial release
// ============================================================================
module blur_engine import blur_pkg::*; #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240,
  parameter int ADDR_W = 17
) (
  input  logic  clk,
  input  logic  reset,
  blur_if.slave bus
);

  localparam int                N          = WIDTH * HEIGHT;
  localparam int                CNT_W      = ADDR_W + 1;
  localparam int                XW         = $clog2(WIDTH);
  localparam int                YW         = $clog2(HEIGHT);
  localparam int                PH_W       = $clog2(WIDTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N - 1);
  localparam logic [CNT_W-1:0]  FIRST_OUT  = CNT_W'(WIDTH + 1);
  localparam logic [XW-1:0]     LAST_X     = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     LAST_Y     = YW'(HEIGHT - 1);
  localparam logic [PH_W-1:0]   FLUSH_LAST = PH_W'(WIDTH);
  localparam logic [PH_W-1:0]   DRAIN_LAST = PH_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic                busy_q, done_q;
  logic                accept;

  logic                shift_q;
  logic [CNT_W-1:0]    kin_q;
  logic [ADDR_W-1:0]   j_q;
  logic [XW-1:0]       jx_q;
  logic [YW-1:0]       jy_q;
  logic                out_en;

  logic                dst_we_q;
  logic [ADDR_W-1:0]   dst_addr_q;
  logic [PIX_W-1:0]    dst_data_q;

  logic [PIX_W-1:0]             lb0_out, lb1_out;
  logic [2:0][PIX_W-1:0]        col_in;
  logic [2:0][1:0][PIX_W-1:0]   win_q;
  logic [PIX_W-1:0]             blur_pix, border_pix, out_pix;
  logic                         is_border;

  assign accept = (state_q == IDLE) && bus.blur_start;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      src_addr_q <= '0;
      ph_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_addr_q <= src_addr_d;
      ph_q       <= ph_d;
      busy_q     <= (state_d == READ) || (state_d == FLUSH) || (state_d == DRAIN);
      done_q     <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d    = state_q;
    src_addr_d = src_addr_q;
    ph_d       = ph_q;
    case (state_q)
      IDLE: begin
        if (bus.blur_start) begin
          state_d    = READ;
          src_addr_d = '0;
        end
      end
      READ: begin
        if (src_addr_q == LAST_ADDR) begin
          state_d = FLUSH;
          ph_d    = '0;
        end else begin
          src_addr_d = src_addr_q + 1'b1;
        end
      end
      FLUSH: begin
        if (ph_q == FLUSH_LAST) begin
          state_d = DRAIN;
          ph_d    = '0;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      DRAIN: begin
        if (ph_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------- line buffers
  blur_line_buffer #(.DEPTH(WIDTH)) u_lb0 (
    .clk    (clk),
    .reset  (reset),
    .push_i (shift_q),
    .din_i  (bus.src_data),
    .dout_o (lb0_out)
  );

  blur_line_buffer #(.DEPTH(WIDTH)) u_lb1 (
    .clk    (clk),
    .reset  (reset),
    .push_i (shift_q),
    .din_i  (lb0_out),
    .dout_o (lb1_out)
  );

  // Newest column comes straight from the inputs so the result can be
  // registered in the same cycle the pixel arrives.
  assign col_in = {bus.src_data, lb0_out, lb1_out};

  always_ff @(posedge clk) begin
    if (shift_q) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= col_in[r];
      end
    end
  end

  // ----------------------------------------------------------- kernel
  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    localparam int LSB = (ch == 0) ? B_LSB : (ch == 1) ? G_LSB : R_LSB;
    logic [8:0][CH_W-1:0] taps;

    always_comb begin
      taps = '0;
      for (int r = 0; r < 3; r++) begin
        taps[r*3 + 0] = win_q[r][0][LSB +: CH_W];
        taps[r*3 + 1] = win_q[r][1][LSB +: CH_W];
        taps[r*3 + 2] = col_in[r][LSB +: CH_W];
      end
    end

    assign blur_pix[LSB +: CH_W] = blur_ch(taps);
  end

  assign is_border = (jx_q == '0) || (jx_q == LAST_X) ||
                     (jy_q == '0) || (jy_q == LAST_Y);

`ifdef BLUR_BORDER_COPY_EN
  assign border_pix = win_q[1][1];
`else
  assign border_pix = '0;
`endif

  assign out_pix = is_border ? border_pix : blur_pix;

  // ------------------------------------------- position and write port
  assign out_en = shift_q && (kin_q >= FIRST_OUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q    <= 1'b0;
      kin_q      <= '0;
      j_q        <= '0;
      jx_q       <= '0;
      jy_q       <= '0;
      dst_we_q   <= 1'b0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
    end else begin
      shift_q  <= (state_q == READ) || (state_q == FLUSH);
      dst_we_q <= out_en;
      if (accept) begin
        kin_q <= '0;
        j_q   <= '0;
        jx_q  <= '0;
        jy_q  <= '0;
      end else begin
        if (shift_q) begin
          kin_q <= kin_q + 1'b1;
        end
        if (out_en) begin
          j_q <= j_q + 1'b1;
          if (jx_q == LAST_X) begin
            jx_q <= '0;
            jy_q <= jy_q + 1'b1;
          end else begin
            jx_q <= jx_q + 1'b1;
          end
        end
      end
      if (out_en) begin
        dst_addr_q <= j_q;
        dst_data_q <= out_pix;
      end
    end
  end

  assign bus.src_addr  = src_addr_q;
  assign bus.dst_addr  = dst_addr_q;
  assign bus.dst_data  = dst_data_q;
  assign bus.dst_we    = dst_we_q;
  assign bus.busy      = busy_q;
  assign bus.blur_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_blur_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_blur_engine
// Brief    : Directed checks of blur_engine on 8x6, 8x8 and 4x3 frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_blur_engine;

`ifdef BLUR_BORDER_COPY_EN
  localparam bit COPY = 1'b1;
`else
  localparam bit COPY = 1'b0;
`endif

  logic clk;
  logic reset;
  logic start;
  int   sel;
  int   checks;
  int   errors;

  logic [11:0] src_a [64];
  logic [11:0] src_b [64];
  logic [11:0] src_c [64];
  logic [11:0] dst   [64];

  int nw, ord_err, done_cnt, done_at, first_we, last_we, busy_first, busy_last;
  logic we_after_rst, busy_after_rst;

  blur_if #(.ADDR_W(17)) ifa ();
  blur_if #(.ADDR_W(17)) ifb ();
  blur_if #(.ADDR_W(17)) ifc ();

  blur_engine #(.WIDTH(8), .HEIGHT(6), .ADDR_W(17)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  blur_engine #(.WIDTH(8), .HEIGHT(8), .ADDR_W(17)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  blur_engine #(.WIDTH(4), .HEIGHT(3), .ADDR_W(17)) dut_c (.clk(clk), .reset(reset), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifa.blur_start = start && (sel == 0);
  assign ifb.blur_start = start && (sel == 1);
  assign ifc.blur_start = start && (sel == 2);

  // Source frame buffers: one-cycle read latency.
  always @(posedge clk) begin
    ifa.src_data <= src_a[ifa.src_addr[5:0]];
    ifb.src_data <= src_b[ifb.src_addr[5:0]];
    ifc.src_data <= src_c[ifc.src_addr[5:0]];
  end

  logic [16:0] m_addr;
  logic [11:0] m_data;
  logic        m_we, m_busy, m_done;

  always_comb begin
    m_addr = ifc.dst_addr; m_data = ifc.dst_data; m_we = ifc.dst_we;
    m_busy = ifc.busy;     m_done = ifc.blur_done;
    if (sel == 0) begin
      m_addr = ifa.dst_addr; m_data = ifa.dst_data; m_we = ifa.dst_we;
      m_busy = ifa.busy;     m_done = ifa.blur_done;
    end else if (sel == 1) begin
      m_addr = ifb.dst_addr; m_data = ifb.dst_data; m_we = ifb.dst_we;
      m_busy = ifb.busy;     m_done = ifb.blur_done;
    end
  end

  // Start strobe in cycle 0; cycle m is the m-th cycle after the start edge.
  task automatic run_frame(input int sel_i, input int budget, input int restart_at, input int reset_at);
    sel = sel_i;
    nw = 0; ord_err = 0; done_cnt = 0; done_at = -1; first_we = -1; last_we = -1;
    busy_first = -1; busy_last = -1; we_after_rst = 1'b1; busy_after_rst = 1'b1;
    for (int i = 0; i < 64; i++) dst[i] = 12'hEEE;
    @(negedge clk);
    start = 1'b1;
    for (int m = 1; m <= budget; m++) begin
      @(negedge clk);
      start = (m == restart_at);
      reset = (m == reset_at);
      if (m_we) begin
        if (first_we < 0) first_we = m;
        last_we = m;
        if (int'(m_addr) != nw) ord_err++;
        if (m_addr < 17'd64) dst[m_addr[5:0]] = m_data;
        nw++;
      end
      if (m_busy) begin
        if (busy_first < 0) busy_first = m;
        busy_last = m;
      end
      if (m_done) begin
        done_cnt++;
        done_at = m;
      end
      if (m == reset_at + 1) begin
        we_after_rst   = m_we;
        busy_after_rst = m_busy;
      end
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (ifc.src_addr !== 17'd0) begin errors++; $display("FAIL rst_src_addr got %h exp 0", ifc.src_addr); end
    checks++; if (ifc.dst_addr !== 17'd0) begin errors++; $display("FAIL rst_dst_addr got %h exp 0", ifc.dst_addr); end
    checks++; if (ifc.dst_data !== 12'h000) begin errors++; $display("FAIL rst_dst_data got %h exp 0", ifc.dst_data); end
    checks++; if (ifc.dst_we !== 1'b0) begin errors++; $display("FAIL rst_dst_we got %b exp 0", ifc.dst_we); end
    checks++; if (ifc.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", ifc.busy); end
    checks++; if (ifc.blur_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", ifc.blur_done); end
  endtask

  task automatic test_constant();
    logic [11:0] exp;
    for (int i = 0; i < 64; i++) src_a[i] = 12'hA5C;
    run_frame(0, 70, -1, -1);
    checks++; if (nw != 48) begin errors++; $display("FAIL const_writes got %0d exp 48", nw); end
    checks++; if (ord_err != 0) begin errors++; $display("FAIL const_order got %0d exp 0", ord_err); end
    checks++; if (done_at != 60) begin errors++; $display("FAIL const_done_at got %0d exp 60", done_at); end
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        if (x == 0 || x == 7 || y == 0 || y == 5) exp = COPY ? 12'hA5C : 12'h000;
        else exp = 12'hA5C;
        checks++;
        if (dst[y*8+x] !== exp) begin
          errors++; $display("FAIL const_pix(%0d,%0d) got %h exp %h", x, y, dst[y*8+x], exp);
        end
      end
    end
  endtask

  task automatic test_impulse();
    int dx, dy;
    logic [11:0] exp;
    for (int i = 0; i < 64; i++) src_b[i] = 12'h000;
    src_b[27] = 12'hF00;
    run_frame(1, 86, -1, -1);
    checks++; if (nw != 64) begin errors++; $display("FAIL imp_writes got %0d exp 64", nw); end
    checks++; if (done_at != 76) begin errors++; $display("FAIL imp_done_at got %0d exp 76", done_at); end
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        dx = (x > 3) ? x - 3 : 3 - x;
        dy = (y > 3) ? y - 3 : 3 - y;
        if (x == 0 || x == 7 || y == 0 || y == 7) exp = 12'h000;
        else if (dx == 0 && dy == 0)              exp = 12'h400;
        else if (dx + dy == 1)                    exp = 12'h200;
        else if (dx == 1 && dy == 1)              exp = 12'h100;
        else                                      exp = 12'h000;
        checks++;
        if (dst[y*8+x] !== exp) begin
          errors++; $display("FAIL imp_pix(%0d,%0d) got %h exp %h", x, y, dst[y*8+x], exp);
        end
      end
    end
  endtask

  task automatic test_border();
    logic [11:0] exp16, exp47;
    for (int i = 0; i < 64; i++) src_a[i] = 12'(i);
    exp16 = COPY ? 12'h010 : 12'h000;
    exp47 = COPY ? 12'h02F : 12'h000;
    run_frame(0, 70, -1, -1);
    checks++; if (nw != 48) begin errors++; $display("FAIL bord_writes got %0d exp 48", nw); end
    checks++; if (ord_err != 0) begin errors++; $display("FAIL bord_order got %0d exp 0", ord_err); end
    checks++; if (dst[16] !== exp16) begin errors++; $display("FAIL bord_(0,2) got %h exp %h", dst[16], exp16); end
    checks++; if (dst[47] !== exp47) begin errors++; $display("FAIL bord_(7,5) got %h exp %h", dst[47], exp47); end
    checks++; if (dst[9]  !== 12'h005) begin errors++; $display("FAIL bord_(1,1) got %h exp 005", dst[9]); end
    checks++; if (dst[10] !== 12'h006) begin errors++; $display("FAIL bord_(2,1) got %h exp 006", dst[10]); end
    checks++; if (dst[17] !== 12'h015) begin errors++; $display("FAIL bord_(1,2) got %h exp 015", dst[17]); end
  endtask

  task automatic test_latency();
    for (int i = 0; i < 64; i++) src_c[i] = 12'h777;
    run_frame(2, 30, -1, -1);
    checks++; if (first_we != 8)   begin errors++; $display("FAIL lat_first_we got %0d exp 8", first_we); end
    checks++; if (last_we != 19)   begin errors++; $display("FAIL lat_last_we got %0d exp 19", last_we); end
    checks++; if (done_at != 20)   begin errors++; $display("FAIL lat_done_at got %0d exp 20", done_at); end
    checks++; if (done_cnt != 1)   begin errors++; $display("FAIL lat_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (nw != 12)        begin errors++; $display("FAIL lat_writes got %0d exp 12", nw); end
    checks++; if (busy_first != 1) begin errors++; $display("FAIL lat_busy_first got %0d exp 1", busy_first); end
    checks++; if (busy_last != 19) begin errors++; $display("FAIL lat_busy_last got %0d exp 19", busy_last); end
    checks++; if (ord_err != 0)    begin errors++; $display("FAIL lat_order got %0d exp 0", ord_err); end
    checks++; if (dst[5] !== 12'h777) begin errors++; $display("FAIL lat_pix5 got %h exp 777", dst[5]); end
    checks++; if (dst[4] !== (COPY ? 12'h777 : 12'h000)) begin errors++; $display("FAIL lat_pix4 got %h", dst[4]); end
  endtask

  task automatic test_start_while_busy();
    run_frame(2, 30, 5, -1);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL swb_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (done_at != 20) begin errors++; $display("FAIL swb_done_at got %0d exp 20", done_at); end
    checks++; if (nw != 12)      begin errors++; $display("FAIL swb_writes got %0d exp 12", nw); end
    checks++; if (first_we != 8) begin errors++; $display("FAIL swb_first_we got %0d exp 8", first_we); end
  endtask

  task automatic test_reset_mid();
    run_frame(2, 40, -1, 10);
    checks++; if (we_after_rst !== 1'b0)   begin errors++; $display("FAIL rmid_we got %b exp 0", we_after_rst); end
    checks++; if (busy_after_rst !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy_after_rst); end
    checks++; if (done_cnt != 0)           begin errors++; $display("FAIL rmid_done_cnt got %0d exp 0", done_cnt); end
    checks++; if (busy_last != 10)         begin errors++; $display("FAIL rmid_busy_last got %0d exp 10", busy_last); end
    run_frame(2, 30, -1, -1);
    checks++; if (done_at != 20)  begin errors++; $display("FAIL rmid_re_done_at got %0d exp 20", done_at); end
    checks++; if (done_cnt != 1)  begin errors++; $display("FAIL rmid_re_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (nw != 12)       begin errors++; $display("FAIL rmid_re_writes got %0d exp 12", nw); end
    checks++; if (ord_err != 0)   begin errors++; $display("FAIL rmid_re_order got %0d exp 0", ord_err); end
    checks++; if (dst[6] !== 12'h777) begin errors++; $display("FAIL rmid_re_pix6 got %h exp 777", dst[6]); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start  = 1'b0;
    sel    = 0;
    reset  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      src_a[i] = 12'h000;
      src_b[i] = 12'h000;
      src_c[i] = 12'h000;
    end
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_constant();
    test_impulse();
    test_border();
    test_latency();
    test_start_while_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
